// File: rtl/fir_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_engine
// Description : Streaming FIR engine. Takes x[n] on an AXI-Stream slave,
//               keeps a circular window of the last N samples in the data
//               BRAM, runs N multiply-accumulates against the tap BRAM and
//               emits y[n] on an AXI-Stream master. N is selectable at
//               runtime, up to pTAP_MAX. ss_tlast ends a transfer early.
//               Optional macro FIR_SAT_EN saturates the output instead of
//               wrapping it.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 32,
  parameter int pLEN_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ap_start,
  output logic                       ap_start_clr,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic [pLEN_WIDTH-1:0]      data_len,
  input  logic [$clog2(pTAP_MAX):0]  tap_num,
  input  logic                       ss_tvalid,
  input  logic [pDATA_WIDTH-1:0]     ss_tdata,
  input  logic                       ss_tlast,
  output logic                       ss_tready,
  output logic                       sm_tvalid,
  output logic [pDATA_WIDTH-1:0]     sm_tdata,
  output logic                       sm_tlast,
  input  logic                       sm_tready,
  output logic [3:0]                 data_WE,
  output logic                       data_EN,
  output logic [pDATA_WIDTH-1:0]     data_Di,
  output logic [pADDR_WIDTH-1:0]     data_A,
  input  logic [pDATA_WIDTH-1:0]     data_Do,
  output logic                       tap_EN,
  output logic [3:0]                 tap_WE,
  output logic [pADDR_WIDTH-1:0]     tap_A,
  input  logic [pDATA_WIDTH-1:0]     tap_Do
);

  localparam int TW = $clog2(pTAP_MAX) + 1;
  localparam int PW = 2 * pDATA_WIDTH;
  localparam int AW = 2 * pDATA_WIDTH + $clog2(pTAP_MAX);

  // S_DRAIN is the cycle where the last product comes back from the BRAMs
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WAIT_X = 3'd2,
    S_MAC    = 3'd3,
    S_DRAIN  = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                   state, state_nxt;
  logic [TW-1:0]            n_taps, n_taps_in, cnt, head, dptr;
  logic [pLEN_WIDTH-1:0]    len, out_cnt;
  logic                     last_in, first_prod, cnt_last;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     prod_ext, acc, acc_sum;
  logic [pDATA_WIDTH-1:0]   y_val;

  // Word index to byte address
  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [TW-1:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  // Clamp the requested tap count into 1..pTAP_MAX
  always_comb begin
    n_taps_in = tap_num;
    if (tap_num == '0)
      n_taps_in = TW'(1);
    else if (tap_num > TW'(pTAP_MAX))
      n_taps_in = TW'(pTAP_MAX);
  end

  assign cnt_last = (cnt == n_taps - TW'(1));

  // Product of the pair issued last cycle, and the running sum including it
  always_comb begin
    prod     = $signed(tap_Do) * $signed(data_Do);
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    acc_sum  = first_prod ? prod_ext : (acc + prod_ext);
  end

`ifdef FIR_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};
  // Clip the final sum into the signed output range
  always_comb begin
    y_val = acc_sum[pDATA_WIDTH-1:0];
    if (acc_sum > SAT_MAX)
      y_val = SAT_MAX[pDATA_WIDTH-1:0];
    else if (acc_sum < SAT_MIN)
      y_val = SAT_MIN[pDATA_WIDTH-1:0];
  end
`else
  // Keep the low bits of the final sum (two's complement wrap)
  always_comb begin
    y_val = acc_sum[pDATA_WIDTH-1:0];
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and all combinational outputs
  always_comb begin
    state_nxt    = state;
    ap_start_clr = 1'b0;
    ap_done      = 1'b0;
    ap_idle      = 1'b0;
    ss_tready    = 1'b0;
    sm_tvalid    = 1'b0;
    data_WE      = 4'h0;
    data_EN      = 1'b0;
    data_Di      = '0;
    data_A       = '0;
    tap_EN       = 1'b0;
    tap_A        = '0;
    case (state)
      S_IDLE: begin
        ap_idle      = 1'b1;
        ap_start_clr = ap_start;
        if (ap_start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(cnt);
        if (cnt_last) state_nxt = S_WAIT_X;
      end
      S_WAIT_X: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN   = 1'b1;
          data_WE   = 4'hF;
          data_Di   = ss_tdata;
          data_A    = word_addr(head);
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        data_EN = 1'b1;
        data_A  = word_addr(dptr);
        tap_EN  = 1'b1;
        tap_A   = word_addr(cnt);
        if (cnt_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_OUT;
      S_OUT: begin
        sm_tvalid = 1'b1;
        if (sm_tready) begin
          ap_done   = sm_tlast;
          state_nxt = sm_tlast ? S_DONE : S_WAIT_X;
        end
      end
      S_DONE: begin
        ap_idle   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tap_WE = 4'h0;

  // Counters, window pointers, accumulator and registered stream output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_taps     <= '0;
      len        <= '0;
      out_cnt    <= '0;
      cnt        <= '0;
      head       <= '0;
      dptr       <= '0;
      last_in    <= 1'b0;
      first_prod <= 1'b0;
      acc        <= '0;
      sm_tdata   <= '0;
      sm_tlast   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            n_taps  <= n_taps_in;
            len     <= (data_len == '0) ? pLEN_WIDTH'(1) : data_len;
            out_cnt <= '0;
            cnt     <= '0;
          end
        end
        S_CLEAR: begin
          if (cnt_last) begin
            cnt  <= '0;
            head <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_WAIT_X: begin
          if (ss_tvalid) begin
            last_in    <= ss_tlast;
            dptr       <= head;
            cnt        <= '0;
            first_prod <= 1'b1;
          end
        end
        S_MAC: begin
          cnt  <= cnt_last ? '0 : cnt + TW'(1);
          // Walk backwards through the circular sample window
          dptr <= (dptr == '0) ? n_taps - TW'(1) : dptr - TW'(1);
          if (cnt != '0) begin
            acc        <= acc_sum;
            first_prod <= 1'b0;
          end
        end
        S_DRAIN: begin
          sm_tdata <= y_val;
          sm_tlast <= (out_cnt == len - pLEN_WIDTH'(1)) || last_in;
        end
        S_OUT: begin
          if (sm_tready) begin
            head     <= (head == n_taps - TW'(1)) ? '0 : head + TW'(1);
            out_cnt  <= out_cnt + pLEN_WIDTH'(1);
            sm_tlast <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
